// File: rtl/demux16_router_ctrl.sv
// rtl/demux16_router_ctrl.sv - packet-aware 1-to-2 stream router with per-port holding registers and beat counters
module demux16_router_ctrl #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dest,
  input  logic              in_last,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  beat_cnt0,
  output logic [CNT_W-1:0]  beat_cnt1,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE0 = 2'd1,
    ROUTE1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               out0_valid_q, out0_valid_d;
  logic               out1_valid_q, out1_valid_d;
  logic [DATA_W-1:0]  out0_data_q, out0_data_d;
  logic [DATA_W-1:0]  out1_data_q, out1_data_d;
  logic [CNT_W-1:0]   beat_cnt0_q, beat_cnt0_d;
  logic [CNT_W-1:0]   beat_cnt1_q, beat_cnt1_d;

  logic can0, can1, sel, xfer, load0, load1, dlv0, dlv1;

  always_comb begin
    can0  = !out0_valid_q || out0_ready;
    can1  = !out1_valid_q || out1_ready;
    // in_dest only matters on the first beat; mid-packet the burst context decides
    sel   = (state_q == IDLE) ? in_dest : (state_q == ROUTE1);
    in_ready = rst_n && (sel ? can1 : can0);
    xfer  = in_valid && in_ready;
    load0 = xfer && !sel;
    load1 = xfer && sel;
    dlv0  = out0_valid_q && out0_ready;
    dlv1  = out1_valid_q && out1_ready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (xfer && !in_last) state_d = in_dest ? ROUTE1 : ROUTE0;
      end
      ROUTE0, ROUTE1: begin
        if (xfer && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out0_valid_d = load0 ? 1'b1 : (dlv0 ? 1'b0 : out0_valid_q);
    out1_valid_d = load1 ? 1'b1 : (dlv1 ? 1'b0 : out1_valid_q);
    out0_data_d  = load0 ? in_data : out0_data_q;
    out1_data_d  = load1 ? in_data : out1_data_q;

    // clear beats increment; counters stick at all-ones
    beat_cnt0_d = beat_cnt0_q;
    beat_cnt1_d = beat_cnt1_q;
    if (cnt_clr) begin
      beat_cnt0_d = '0;
      beat_cnt1_d = '0;
    end else begin
      if (dlv0 && (beat_cnt0_q != {CNT_W{1'b1}})) beat_cnt0_d = beat_cnt0_q + 1'b1;
      if (dlv1 && (beat_cnt1_q != {CNT_W{1'b1}})) beat_cnt1_d = beat_cnt1_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      out0_valid_q <= 1'b0;
      out1_valid_q <= 1'b0;
      out0_data_q  <= '0;
      out1_data_q  <= '0;
      beat_cnt0_q  <= '0;
      beat_cnt1_q  <= '0;
    end else begin
      state_q      <= state_d;
      out0_valid_q <= out0_valid_d;
      out1_valid_q <= out1_valid_d;
      out0_data_q  <= out0_data_d;
      out1_data_q  <= out1_data_d;
      beat_cnt0_q  <= beat_cnt0_d;
      beat_cnt1_q  <= beat_cnt1_d;
    end
  end

  assign out0_valid = out0_valid_q;
  assign out1_valid = out1_valid_q;
  assign out0_data  = out0_data_q;
  assign out1_data  = out1_data_q;
  assign beat_cnt0  = beat_cnt0_q;
  assign beat_cnt1  = beat_cnt1_q;
  assign busy       = (state_q != IDLE) || out0_valid_q || out1_valid_q;

endmodule

// File: tb/tb_demux16_router_ctrl.sv
// tb/tb_demux16_router_ctrl.sv - directed self-checking bench for demux16_router_ctrl
module tb_demux16_router_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_dest;
  logic        in_last;
  logic        out0_valid, out1_valid;
  logic        out0_ready, out1_ready;
  logic [15:0] out0_data, out1_data;
  logic        cnt_clr;
  logic [7:0]  beat_cnt0, beat_cnt1;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  demux16_router_ctrl #(.DATA_W(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .in_last    (in_last),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt_clr    (cnt_clr),
    .beat_cnt0  (beat_cnt0),
    .beat_cnt1  (beat_cnt1),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge, then let combinational outputs settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] dests;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'h0; in_dest = 1'b0; in_last = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0; cnt_clr = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt0", beat_cnt0, 0);
    chk("rst_cnt1", beat_cnt1, 0);
    chk("rst_out0_data", out0_data, 0);

    // single-beat packet to port 1
    rst_n = 1'b1; in_valid = 1'b1; in_dest = 1'b1; in_last = 1'b1; in_data = 16'hA5A5; out1_ready = 1'b1;
    #1;
    chk("sb_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("sb_out1_valid", out1_valid, 1);
    chk("sb_out1_data", out1_data, 16'hA5A5);
    chk("sb_cnt1_pre", beat_cnt1, 0);
    chk("sb_out0_valid", out0_valid, 0);
    tick();
    chk("sb_cnt1", beat_cnt1, 1);
    chk("sb_out1_drained", out1_valid, 0);
    chk("sb_busy_idle", busy, 0);

    // 4-beat packet to port 0, in_dest toggling after the first beat
    out0_ready = 1'b1;
    dests = 2'b10;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 16'(i); in_dest = (i == 1) ? 1'b0 : dests[i % 2]; in_last = (i == 4);
      #1;
      chk($sformatf("burst_in_ready_%0d", i), in_ready, 1);
      tick();
      chk($sformatf("burst_out0_data_%0d", i), out0_data, i);
      chk($sformatf("burst_out0_valid_%0d", i), out0_valid, 1);
      chk($sformatf("burst_out1_valid_%0d", i), out1_valid, 0);
      chk($sformatf("burst_cnt0_%0d", i), beat_cnt0, i - 1);
    end
    in_valid = 1'b0;
    tick();
    chk("burst_cnt0", beat_cnt0, 4);
    chk("burst_out1_data_kept", out1_data, 16'hA5A5);
    chk("burst_cnt1_kept", beat_cnt1, 1);
    chk("burst_busy", busy, 0);

    // stall on port 0 while port 1 drains independently
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_dest = 1'b1; in_last = 1'b1; in_data = 16'h1111;
    tick();
    chk("st_out1_loaded", out1_data, 16'h1111);
    in_dest = 1'b0; in_last = 1'b0; in_data = 16'h0B01;
    #1;
    chk("st_first_ready", in_ready, 1);
    tick();
    in_dest = 1'b1; in_last = 1'b1; in_data = 16'h0B02; out1_ready = 1'b1;
    #1;
    chk("st_stalled_ready", in_ready, 0);
    tick();
    chk("st_out1_drained", out1_valid, 0);
    chk("st_cnt1", beat_cnt1, 2);
    chk("st_out0_held", out0_data, 16'h0B01);
    chk("st_out0_valid", out0_valid, 1);
    chk("st_still_stalled", in_ready, 0);
    out0_ready = 1'b1;
    #1;
    chk("st_released", in_ready, 1);
    tick();
    chk("st_out0_second", out0_data, 16'h0B02);
    chk("st_out1_untouched", out1_valid, 0);
    chk("st_cnt0", beat_cnt0, 5);
    in_valid = 1'b0;
    tick();
    chk("st_cnt0_end", beat_cnt0, 6);
    chk("st_busy_end", busy, 0);

    // 300 deliveries on port 1: counter saturates
    out1_ready = 1'b1; in_valid = 1'b1; in_dest = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = 16'(16'h4000 + i);
      tick();
      if (i == 252) chk("sat_cnt1_254", beat_cnt1, 254);
    end
    in_valid = 1'b0;
    chk("sat_last_data", out1_data, 16'h4000 + 299);
    tick();
    chk("sat_cnt1", beat_cnt1, 255);
    chk("sat_out1_valid", out1_valid, 0);
    in_valid = 1'b1; in_data = 16'h5555;
    tick();
    in_valid = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cnt1", beat_cnt1, 0);
    chk("clr_cnt0", beat_cnt0, 0);
    chk("clr_out1_valid", out1_valid, 0);

    // reset in the middle of a ROUTE1 burst
    out1_ready = 1'b0; in_valid = 1'b1; in_dest = 1'b1; in_last = 1'b0; in_data = 16'h2222;
    tick();
    chk("mr_out1_valid", out1_valid, 1);
    chk("mr_busy", busy, 1);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("mr_in_ready_rst", in_ready, 0);
    tick();
    chk("mr_out1_cleared", out1_valid, 0);
    chk("mr_out1_data", out1_data, 0);
    chk("mr_busy_cleared", busy, 0);
    rst_n = 1'b1; in_valid = 1'b1; in_dest = 1'b0; in_last = 1'b1; in_data = 16'h3333; out0_ready = 1'b1;
    #1;
    chk("mr_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("mr_out0_valid", out0_valid, 1);
    chk("mr_out0_data", out0_data, 16'h3333);
    chk("mr_out1_idle", out1_valid, 0);
    tick();
    chk("mr_cnt0", beat_cnt0, 1);
    chk("mr_busy_end", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux16_router_ctrl.md
DEMUX16_ROUTER_CTRL -- requirements
Module: demux16_router_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of the data word.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of each beat counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 in_valid  input  1  SHALL indicate that the upstream beat is valid.
REQ-006 in_ready  output  1  SHALL indicate that the router accepts the beat this cycle.
REQ-007 in_data  input  DATA_W  SHALL carry the upstream data word.
REQ-008 in_dest  input  1  SHALL select the destination port (0/1), sampled only on the first beat of a packet.
REQ-009 in_last  input  1  SHALL mark the final beat of a packet.
REQ-010 out0_valid, out1_valid  output  1 each  SHALL indicate that the port holding register is full.
REQ-011 out0_ready, out1_ready  input  1 each  SHALL indicate downstream acceptance on each port.
REQ-012 out0_data, out1_data  output  DATA_W each  SHALL carry the port holding-register contents.
REQ-013 cnt_clr  input  1  SHALL synchronously clear both beat counters.
REQ-014 beat_cnt0, beat_cnt1  output  CNT_W each  SHALL give the number of beats delivered per port.
REQ-015 busy  output  1  SHALL be high when the state is not IDLE, or when out0_valid or out1_valid is high.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ROUTE0 and ROUTE1.
REQ-017 Transfer SHALL occur when in_valid && in_ready; delivery on port k SHALL occur when outk_valid && outk_ready.
REQ-018 Port k SHALL be able to accept a beat when !outk_valid || outk_ready (fill while draining in the same cycle).
REQ-019 in_ready SHALL follow the selected port: in IDLE it equals can-accept of port in_dest; in ROUTEk it equals can-accept of port k. in_ready is combinational and SHALL NOT depend on in_valid.
REQ-020 IDLE transitions: a transfer with in_last=0 SHALL go to ROUTE[in_dest]; a transfer with in_last=1 SHALL stay in IDLE (single-beat packet).
REQ-021 ROUTEk behaviour: in_dest SHALL be ignored and every beat SHALL go to port k; a transfer with in_last=1 SHALL return to IDLE.
REQ-022 On a transfer, the target port SHALL load in_data and set outk_valid=1 on the next edge, giving 1-cycle latency.
REQ-023 A delivery without a simultaneous refill SHALL clear outk_valid on the next edge.
REQ-024 outk_data SHALL hold its last value whenever no new beat is loaded into port k.
REQ-025 The non-selected port SHALL be left unchanged apart from its own draining.
REQ-026 With outk_ready held high, port k SHALL sustain 1 beat/cycle.
REQ-027 A stall on the selected port SHALL stall the input only; the other port SHALL continue to drain independently.
REQ-028 Each beat_cntk SHALL increment by 1 per delivery on port k and saturate at all-ones (no wrap).
REQ-029 cnt_clr SHALL take priority over increment: cnt_clr together with a delivery SHALL yield 0.
REQ-030 A beat SHALL never be duplicated or dropped outside reset.

Reset
REQ-031 While rst_n=0 at a rising edge, the block SHALL set the state to IDLE and clear out0_valid, out1_valid, out0_data, out1_data, beat_cnt0 and beat_cnt1.
REQ-032 While rst_n=0, in_ready SHALL be forced to 0, and busy SHALL read 0 after the reset edge.
REQ-033 Reset mid-packet or with full holding registers SHALL discard the held beats and the burst context; the next accepted beat SHALL be treated as a first beat.

Verification
REQ-034 Scenario: after reset, in_dest=1, in_last=1, in_data=0xA5A5, out1_ready=1 -> out1_valid=1 with 0xA5A5 one cycle later; beat_cnt1=1 one cycle after that; state stays IDLE.
REQ-035 Scenario: 4-beat packet 0x0001..0x0004 with dest=0 on the first beat and in_dest toggling on later beats -> all four beats appear on port 0 in order; port 1 stays untouched; beat_cnt0=4.
REQ-036 Scenario: out0_ready=0 during a ROUTE0 burst -> one beat is held, in_ready=0 and the input stalls; meanwhile a previously loaded port-1 beat still drains when out1_ready=1.
REQ-037 Scenario: 300 deliveries on port 1 with CNT_W=8 -> beat_cnt1=255; cnt_clr asserted together with a delivery -> beat_cnt1=0.
REQ-038 Scenario: rst_n=0 for one cycle mid ROUTE1 burst with out1_valid=1 -> out1_valid=0 and state IDLE; the next beat with in_dest=0 routes to port 0.
